// File: rtl/decode_stage_if.sv
// Decode-stage bus: the fetch-to-decode register outputs, the writeback
// port, the redirect request back to fetch, and the decode-to-execute register.
interface decode_stage_if;
    // fetch-to-decode register
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    // writeback port into the register file
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    // redirect request to fetch (combinational)
    logic        PCSrcD;
    logic        JalD;
    logic [31:0] PCTargetD;

    // decode-to-execute register
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    // decode stage side
    modport slave (
        input  InstrD, PCD, PCPlus4D,
        input  RegWriteW, RdW, ResultW,
        output PCSrcD, JalD, PCTargetD,
        output RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E,
        output RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE
    );

    // pipeline / environment side
    modport master (
        output InstrD, PCD, PCPlus4D,
        output RegWriteW, RdW, ResultW,
        input  PCSrcD, JalD, PCTargetD,
        input  RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E,
        input  RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, ALUControlE
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, control
// decode, immediate generation, branch/jump resolution in decode, and the
// single-slot squash of the wrong-path instruction after a redirect.
//
// Squash FSM states:
//   state | meaning
//   LIVE  | InstrD is on the correct path; decode normally, redirects allowed
//   KILL  | InstrD is the wrong-path fetch after a redirect; issue a bubble,
//         | suppress redirects, return to LIVE on the next edge
module decode_stage (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    typedef enum logic {
        LIVE = 1'b0,
        KILL = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_sel_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;

    // instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign opcode = bus.InstrD[6:0];
    assign rd     = bus.InstrD[11:7];
    assign funct3 = bus.InstrD[14:12];
    assign rs1    = bus.InstrD[19:15];
    assign rs2    = bus.InstrD[24:20];
    assign funct7 = bus.InstrD[31:25];

    state_t      kill_q;
    logic        live;

    assign live = (kill_q == LIVE);

    // register file and bypassed read data
    logic [31:0] regs [0:31];
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_active;

    assign wb_active = bus.RegWriteW && (bus.RdW != 5'd0);

    // register file write; x0 is never written so it stays at its reset value of 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= '0;
            end
        end else if (wb_active) begin
            regs[bus.RdW] <= bus.ResultW;
        end
    end

    // combinational reads with write-through so a same-cycle writeback is seen
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) begin
            rd1 = (wb_active && (bus.RdW == rs1)) ? bus.ResultW : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rd2 = (wb_active && (bus.RdW == rs2)) ? bus.ResultW : regs[rs2];
        end
    end

    // immediates in every format; B and J carry an implicit zero LSB
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign imm_i = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
    assign imm_s = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
    assign imm_b = {{19{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[7],
                    bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
    assign imm_j = {{11{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[19:12],
                    bus.InstrD[20], bus.InstrD[30:21], 1'b0};
    assign imm_u = {bus.InstrD[31:12], 12'd0};

    // decoded controls
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    imm_sel_t    imm_sel;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;

    // control decode; anything not recognised stays an all-zero bubble
    always_comb begin
        valid       = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        imm_sel     = IMM_NONE;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_lui      = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: begin valid = 1'b1; alu_control = ALU_ADD; end
                        3'b111: begin valid = 1'b1; alu_control = ALU_AND; end
                        3'b110: begin valid = 1'b1; alu_control = ALU_OR;  end
                        3'b010: begin valid = 1'b1; alu_control = ALU_SLT; end
                        default: valid = 1'b0;
                    endcase
                end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
                    valid       = 1'b1;
                    alu_control = ALU_SUB;
                end
                reg_write = valid;
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin valid = 1'b1; alu_control = ALU_ADD; end
                    3'b111: begin valid = 1'b1; alu_control = ALU_AND; end
                    3'b110: begin valid = 1'b1; alu_control = ALU_OR;  end
                    3'b010: begin valid = 1'b1; alu_control = ALU_SLT; end
                    default: valid = 1'b0;
                endcase
                reg_write = valid;
                alu_src   = valid;
                imm_sel   = IMM_I;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    valid      = 1'b1;
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    result_src = 2'b01;
                    imm_sel    = IMM_I;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    valid     = 1'b1;
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_sel   = IMM_S;
                end
            end
            OP_BRANCH: begin
                if ((funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101)) begin
                    valid       = 1'b1;
                    is_branch   = 1'b1;
                    alu_control = ALU_SUB;
                    imm_sel     = IMM_B;
                end
            end
            OP_JAL: begin
                valid      = 1'b1;
                is_jal     = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
                imm_sel    = IMM_J;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    valid      = 1'b1;
                    is_jalr    = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    imm_sel    = IMM_I;
                end
            end
            OP_LUI: begin
                valid       = 1'b1;
                is_lui      = 1'b1;
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = ALU_PASS;
                imm_sel     = IMM_U;
            end
            default: valid = 1'b0;
        endcase
    end

    // immediate selected for the execute stage
    logic [31:0] imm_ext;

    // pick the immediate matching the decoded format
    always_comb begin
        imm_ext = '0;
        case (imm_sel)
            IMM_I:   imm_ext = imm_i;
            IMM_S:   imm_ext = imm_s;
            IMM_B:   imm_ext = imm_b;
            IMM_J:   imm_ext = imm_j;
            IMM_U:   imm_ext = imm_u;
            default: imm_ext = '0;
        endcase
    end

    // branch condition from the bypassed register-file values; blt/bge signed
    logic taken;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (rd1 == rd2);
            3'b001:  taken = (rd1 != rd2);
            3'b100:  taken = ($signed(rd1) < $signed(rd2));
            3'b101:  taken = ($signed(rd1) >= $signed(rd2));
            default: taken = 1'b0;
        endcase
    end

    // redirect request: suppressed while the current slot is being squashed
    assign bus.PCSrcD = live && valid && ((is_branch && taken) || is_jalr);
    assign bus.JalD   = live && valid && is_jal;

    // redirect target; the default is the branch target even when not taken
    always_comb begin
        bus.PCTargetD = bus.PCD + imm_b;
        if (valid && is_jal) begin
            bus.PCTargetD = bus.PCD + imm_j;
        end else if (valid && is_jalr) begin
            bus.PCTargetD = (rd1 + imm_i) & 32'hFFFF_FFFE;
        end
    end

    // squash FSM: one wrong-path slot follows every redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_q <= LIVE;
        end else begin
            case (kill_q)
                LIVE:    kill_q <= (bus.PCSrcD || bus.JalD) ? KILL : LIVE;
                KILL:    kill_q <= LIVE;
                default: kill_q <= LIVE;
            endcase
        end
    end

    // decode-to-execute register; squashed or illegal slots load an all-zero bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.ImmExtE     <= '0;
            bus.Rs1E        <= '0;
            bus.Rs2E        <= '0;
            bus.RdE         <= '0;
            bus.PCE         <= '0;
            bus.PCPlus4E    <= '0;
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.ALUControlE <= 3'b000;
        end else if (!live || !valid) begin
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.ImmExtE     <= '0;
            bus.Rs1E        <= '0;
            bus.Rs2E        <= '0;
            bus.RdE         <= '0;
            bus.PCE         <= '0;
            bus.PCPlus4E    <= '0;
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.ALUControlE <= 3'b000;
        end else begin
            // lui has no rs1 operand; a zero A input lets pass-B and add agree
            bus.RD1E        <= is_lui ? 32'd0 : rd1;
            bus.RD2E        <= rd2;
            bus.ImmExtE     <= imm_ext;
            bus.Rs1E        <= rs1;
            bus.Rs2E        <= rs2;
            bus.RdE         <= rd;
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
            bus.RegWriteE   <= reg_write;
            bus.MemWriteE   <= mem_write;
            bus.ALUSrcE     <= alu_src;
            bus.ResultSrcE  <= result_src;
            bus.ALUControlE <= alu_control;
        end
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipeline decode stage of the 5-stage RV32I core; consumes the fetch-to-decode register outputs and returns the redirect request (`PCSrcD`, `JalD`, `PCTargetD`) to fetch. It holds the 32x32 register file, decodes control, generates immediates, and resolves branches and jumps in decode. It squashes the single wrong-path instruction that fetch delivers after a taken redirect. All decoded results go into the decode-to-execute pipeline register.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `InstrD` in 32: instruction from fetch register.
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: `PCD`+4.
- `RegWriteW` in 1: writeback write enable.
- `RdW` in 5: writeback destination.
- `ResultW` in 32: writeback data.
- `PCSrcD` out 1: taken branch or `jalr`; combinational.
- `JalD` out 1: `jal`; combinational.
- `PCTargetD` out 32: redirect target; combinational.
- `RD1E`, `RD2E` out 32 each: registered rs1/rs2 values.
- `ImmExtE` out 32: registered immediate.
- `Rs1E`, `Rs2E`, `RdE` out 5 each: registered register indices.
- `PCE`, `PCPlus4E` out 32 each: registered PC values.
- `RegWriteE`, `MemWriteE`, `ALUSrcE` out 1 each: registered controls.
- `ResultSrcE` out 2: 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlE` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 pass-B.

## Operation
- **Supported instructions:**
  - R-type: add, sub, and, or, slt.
  - I-type: addi, andi, ori, slti.
  - Memory: lw, sw.
  - Branches: beq, bne, blt, bge.
  - Jumps: jal, jalr.
  - lui.
  - Any other opcode or funct decodes as a bubble.
- **Immediates:** I, S, B, J, U formats, sign-extended to 32 bits. B and J immediates have bit 0 = 0. U places `imm[31:12]` with low 12 bits zero.
- **Register file:**
  - x0 always reads 0 and ignores writes.
  - Write happens on posedge `clk` when `RegWriteW` and `RdW` != 0.
  - Reads are combinational, with write-through bypass: if `RegWriteW`, `RdW` != 0, and `RdW` == rs, the read returns `ResultW`.
- **Branch compare:** uses the bypassed register-file values only. blt and bge are signed. Operand hazards against E and M are resolved outside this block.
- **Redirect:**
  - Branch taken: `PCSrcD`=1, `PCTargetD` = `PCD` + ImmB.
  - jal: `JalD`=1, `PCTargetD` = `PCD` + ImmJ.
  - jalr: `PCSrcD`=1, `PCTargetD` = (rs1 + ImmI) & ~1.
  - Otherwise `PCTargetD` = `PCD` + ImmB, and `PCSrcD` = `JalD` = 0.
  - All target arithmetic is mod 2^32; wrap-around is silent.
- **Squash FSM** (1-bit state `kill_q`):
  - LIVE (`kill_q`=0): decode normally. If `PCSrcD` or `JalD` = 1, go to KILL on the next edge.
  - KILL (`kill_q`=1): the current `InstrD` is the wrong-path instruction.
    - `PCSrcD` = `JalD` = 0.
    - The E register loads a bubble.
    - Always returns to LIVE on the next edge.
  - A branch in a killed slot never redirects, so KILL→KILL cannot occur.
- **Bubble:** `RegWriteE` = `MemWriteE` = `ALUSrcE` = 0, `ResultSrcE` = 00, `ALUControlE` = 000. All data and index fields are 0.
- **Per-instruction controls:**
  - jal/jalr: `RegWriteE`=1, `ResultSrcE`=10.
  - lui: `ALUSrcE`=1, `ALUControlE`=110, `RD1E`=0.
  - sw: `RegWriteE`=0, `MemWriteE`=1, `ALUSrcE`=1.
  - lw: `ResultSrcE`=01, `ALUSrcE`=1.
  - Branches: `RegWriteE`=0, `MemWriteE`=0.

## Timing
- Redirect outputs are valid in the same cycle as `InstrD`; there is no pipeline state on that path.
- E outputs update on posedge `clk`: 1-cycle latency from `InstrD`. Throughput is 1 instruction per cycle, with no stalls.
- Exactly one instruction after each redirect is squashed.
- **Reset (async):**
  - All E outputs = 0.
  - `kill_q` = 0.
  - All 31 writable registers = 0.
  - Redirect outputs reflect the current `InstrD`. Fetch resets `InstrD` to 0, which is an illegal opcode, so `PCSrcD` = `JalD` = 0.
- **Reset mid-operation:** a pending KILL is discarded. The next instruction after reset release decodes LIVE.
- **Simultaneous writeback and read of the same register:** bypassed data is used for both the branch compare and `RD1E`/`RD2E`.

## Test plan
- **ALU then writeback:** x1=5, x2=7 via the W port; `InstrD`=add x3,x1,x2 → next edge `RD1E`=5, `RD2E`=7, `RdE`=3, `RegWriteE`=1, `ALUControlE`=000.
- **Bypass:** `RegWriteW`=1, `RdW`=4, `ResultW`=0xDEADBEEF in the same cycle as `InstrD`=addi x5,x4,-1 → `RD1E`=0xDEADBEEF, `ImmExtE`=0xFFFFFFFF. A write to x0 leaves reads of x0 at 0.
- **Branch + squash:** x1=x2=3, `PCD`=0x100, beq x1,x2,+16 → `PCSrcD`=1, `PCTargetD`=0x110. The next cycle's `InstrD` (an add) yields a bubble. The instruction after that decodes normally.
- **Not-taken branch:** bne with equal operands → `PCSrcD`=0 and no squash. blt with x1=-1, x2=1 → taken (signed compare).
- **jal and jalr:**
  - jal at `PCD`=0x200, offset -8 → `JalD`=1, `PCTargetD`=0x1F8, `PCPlus4E`=0x204, `ResultSrcE`=10.
  - jalr with x1=0x301, imm 0 → `PCTargetD`=0x300.
- **Reset mid-KILL and illegal opcode:** assert `rst` during the KILL cycle → all E outputs 0, and the first post-reset instruction is decoded normally. `InstrD`=0xFFFFFFFF → bubble.
